// File: rtl/label_map_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the label map writer: label codes, FSM states and
// the address-width helper used to size the label RAM port.
package label_map_pkg;

    // Label codes stored in the label RAM. VISITED belongs to downstream
    // consumers; the writer itself only ever produces BLACK or WHITE.
    localparam logic [1:0] LBL_BLACK   = 2'b00;
    localparam logic [1:0] LBL_WHITE   = 2'b01;
    localparam logic [1:0] LBL_VISITED = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    // Bits needed to index n entries; never narrower than one bit so that a
    // degenerate single-entry map still has a legal port.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/label_map_writer.sv
`timescale 1ns/1ps
// Label map writer: binarises an incoming luma stream against a per-frame
// threshold and writes one 2-bit label per pixel into an external label RAM.
// Once a complete, well-formed frame has been written the map is announced to
// the consumer, which hands it back with detection_valid (or loses it to a
// timeout). Malformed frames are reported and never announced.
//
// Stream handshake: a beat transfers on a rising clk edge where s_valid and
// s_ready are both high; s_ready depends only on the FSM state (high in IDLE
// and FILL, low in COMMIT and READY) and never on s_valid, so the producer may
// hold s_valid and its data stable until the transfer happens.
module label_map_writer
    import label_map_pkg::*;
#(
    parameter int IMG_WIDTH      = 640,
    parameter int IMG_HEIGHT     = 480,
    parameter int TIMEOUT_CYCLES = 4194304,
    localparam int N             = IMG_WIDTH * IMG_HEIGHT,
    localparam int AW            = addr_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    input  logic          s_sof,
    input  logic          s_eof,
    input  logic [7:0]    threshold,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [1:0]    wr_data,
    output logic          valid_to_read,
    input  logic          detection_valid,
    output logic          frame_error,
    output logic          timeout,
    output logic [15:0]   frames_written
);

    localparam int              TW        = addr_width(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0]   LAST_IDX  = AW'(N - 1);
    localparam logic [TW-1:0]   WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q;       // index of the next pixel in the frame
    logic [7:0]    thr_q;       // threshold latched on the sof beat
    logic [TW-1:0] wait_q;      // cycles spent in READY

    logic          accept;
    logic [AW-1:0] beat_idx;
    logic          beat_last;
    logic [7:0]    thr_use;
    logic [1:0]    label;
    logic          wait_done;

    logic          do_write;
    logic          err_d;
    logic          commit_d;
    logic          timeout_d;

    // A sof beat is always pixel 0 and is judged against the threshold
    // presented with it, since that is the value being latched.
    assign accept    = s_valid && s_ready;
    assign beat_idx  = s_sof ? '0 : idx_q;
    assign beat_last = (beat_idx == LAST_IDX);
    assign thr_use   = s_sof ? threshold : thr_q;
    assign label     = (s_data >= thr_use) ? LBL_WHITE : LBL_BLACK;
    assign wait_done = (wait_q == WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a sof beat in IDLE or FILL is treated identically
    // (restart at pixel 0), so both states share the beat rule.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (accept && (state_q == ST_FILL || s_sof)) begin
                    if (beat_last)             state_d = s_eof ? ST_COMMIT : ST_IDLE;
                    else if (s_eof && !s_sof)  state_d = ST_IDLE;
                    else                       state_d = ST_FILL;
                end
            end
            ST_COMMIT: state_d = ST_READY;
            ST_READY: begin
                if (detection_valid || wait_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: handshake, write strobe and the event pulses to register.
    always_comb begin
        s_ready   = (state_q == ST_IDLE) || (state_q == ST_FILL);
        do_write  = accept && (state_q == ST_FILL || s_sof);
        err_d     = 1'b0;
        if (do_write) begin
            if (beat_last)  err_d = !s_eof;
            else if (s_sof) err_d = (state_q == ST_FILL) || s_eof;
            else            err_d = s_eof;
        end
        commit_d  = (state_q == ST_COMMIT);
        timeout_d = (state_q == ST_READY) && !detection_valid && wait_done;
    end

    // Datapath: one-cycle write register, pixel index, threshold latch,
    // READY wait counter and the registered event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= LBL_BLACK;
            idx_q          <= '0;
            thr_q          <= '0;
            wait_q         <= '0;
            frame_error    <= 1'b0;
            valid_to_read  <= 1'b0;
            timeout        <= 1'b0;
            frames_written <= '0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_addr <= beat_idx;
                wr_data <= label;
                idx_q   <= beat_idx + 1'b1;
            end
            if (accept && s_sof) thr_q <= threshold;
            wait_q        <= (state_q == ST_READY) ? wait_q + 1'b1 : '0;
            frame_error   <= err_d;
            valid_to_read <= commit_d;
            timeout       <= timeout_d;
            if (commit_d) frames_written <= frames_written + 16'd1;
        end
    end

endmodule

// File: tb/tb_label_map_writer.sv
`timescale 1ns/1ps
// Bench for label_map_writer on an 8x4 image with a 64-cycle READY timeout.
module tb_label_map_writer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int TO = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data = '0;
    logic          s_sof = 1'b0;
    logic          s_eof = 1'b0;
    logic [7:0]    threshold = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_data;
    logic          valid_to_read;
    logic          detection_valid = 1'b0;
    logic          frame_error;
    logic          timeout;
    logic [15:0]   frames_written;

    label_map_writer #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .s_sof           (s_sof),
        .s_eof           (s_eof),
        .threshold       (threshold),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .valid_to_read   (valid_to_read),
        .detection_valid (detection_valid),
        .frame_error     (frame_error),
        .timeout         (timeout),
        .frames_written  (frames_written)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int vtr_cnt      = 0;
    int err_cnt      = 0;
    int to_cnt       = 0;

    // ---------------- scoreboard ----------------
    // Each entry is {address, label} of one expected RAM write, in order.
    logic [AW+1:0] exp_q[$];
    logic [AW+1:0] exp_w;

    always @(negedge clk) begin
        if (valid_to_read) vtr_cnt++;
        if (frame_error)   err_cnt++;
        if (timeout)       to_cnt++;
        if (wr_en) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", wr_addr, wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({wr_addr, wr_data} !== exp_w) begin
                    tests_failed++;
                    $display("FAIL write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             wr_addr, wr_data, exp_w[AW+1:2], exp_w[1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic sof, input logic eof);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eof   = eof;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eof   = 1'b0;
    endtask

    task automatic push_write(input int a, input logic [7:0] d, input logic [7:0] thr);
        logic [AW-1:0] addr;
        addr = AW'(a);
        exp_q.push_back({addr, (d >= thr) ? 2'b01 : 2'b00});
    endtask

    // Called right after the eof beat is accepted: one COMMIT cycle, then the
    // announce pulse with the updated frame count.
    task automatic expect_announce(input int exp_frames);
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b0 || valid_to_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL commit_cycle: got s_ready=%0b valid_to_read=%0b, required 0 0", s_ready, valid_to_read);
        end
        @(negedge clk);
        tests_run++;
        if (valid_to_read !== 1'b1 || frames_written !== 16'(exp_frames)) begin
            tests_failed++;
            $display("FAIL announce: got valid_to_read=%0b frames_written=%0d, required 1 %0d",
                     valid_to_read, frames_written, exp_frames);
        end
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL writes_missing: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic send_good_frame(input logic [7:0] thr, input bit gaps, input int exp_frames);
        logic [7:0] d;
        for (int i = 0; i < N; i++) begin
            d = 8'($urandom_range(0, 255));
            threshold = (i == 0) ? thr : 8'($urandom_range(0, 255));
            push_write(i, d, thr);
            send_beat(d, i == 0, i == N - 1);
            if (gaps && i != N - 1 && $urandom_range(0, 2) == 0) idle_cycle();
        end
        expect_announce(exp_frames);
    endtask

    task automatic release_map();
        detection_valid = 1'b1;
        @(posedge clk); #1;
        detection_valid = 1'b0;
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release: got s_ready=%0b, required 1", s_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({wr_en, valid_to_read, frame_error, timeout} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_pulses: got wr_en=%0b vtr=%0b ferr=%0b to=%0b, required 0 0 0 0",
                     wr_en, valid_to_read, frame_error, timeout);
        end
        tests_run++;
        if (wr_addr !== '0 || wr_data !== 2'b00 || frames_written !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got addr=%0d data=%0d frames=%0d, required 0 0 0",
                     wr_addr, wr_data, frames_written);
        end
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got s_ready=%0b, required 1", s_ready);
        end
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_ramp_frame();
        int e0;
        e0 = err_cnt;
        threshold = 8'd128;
        for (int i = 0; i < N; i++) begin
            push_write(i, 8'(i * 8), 8'd128);
            if (i > 0) threshold = 8'(255 - i);
            send_beat(8'(i * 8), i == 0, i == N - 1);
        end
        expect_announce(1);
        tests_run++;
        if (err_cnt != e0) begin
            tests_failed++;
            $display("FAIL ramp_no_error: got %0d error pulses, required 0", err_cnt - e0);
        end
        release_map();
    endtask

    task automatic test_no_sof();
        for (int i = 0; i < 5; i++) send_beat(8'($urandom_range(0, 255)), 1'b0, i == 4);
        repeat (2) idle_cycle();
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL discard_idle: got s_ready=%0b, required 1", s_ready);
        end
        send_good_frame(8'($urandom_range(1, 254)), 1'b1, 2);
        release_map();
    endtask

    task automatic test_early_eof();
        int e0, v0;
        logic [7:0] d;
        e0 = err_cnt;
        v0 = vtr_cnt;
        threshold = 8'd100;
        for (int i = 0; i <= 10; i++) begin
            d = 8'($urandom_range(0, 255));
            push_write(i, d, 8'd100);
            send_beat(d, i == 0, i == 10);
        end
        @(negedge clk);
        tests_run++;
        if (frame_error !== 1'b1 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL early_eof_error: got frame_error=%0b s_ready=%0b, required 1 1", frame_error, s_ready);
        end
        repeat (5) @(negedge clk);
        #1;
        tests_run++;
        if (vtr_cnt != v0 || err_cnt != e0 + 1) begin
            tests_failed++;
            $display("FAIL early_eof_counts: got announces=%0d errors=%0d, required 0 1", vtr_cnt - v0, err_cnt - e0);
        end
        send_good_frame(8'd77, 1'b0, 3);
        release_map();
    endtask

    task automatic test_sof_restart();
        int e0;
        logic [7:0] d;
        e0 = err_cnt;
        threshold = 8'd50;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom_range(0, 255));
            push_write(i, d, 8'd50);
            send_beat(d, i == 0, 1'b0);
            threshold = 8'($urandom_range(0, 255));
        end
        threshold = 8'd200;
        for (int i = 0; i < N; i++) begin
            d = (i == 0) ? 8'd200 : 8'($urandom_range(0, 255));
            push_write(i, d, 8'd200);
            send_beat(d, i == 0, i == N - 1);
            threshold = 8'($urandom_range(0, 255));
            if (i == 0) begin
                @(negedge clk);
                tests_run++;
                if (frame_error !== 1'b1 || wr_addr !== '0) begin
                    tests_failed++;
                    $display("FAIL restart_error: got frame_error=%0b addr=%0d, required 1 0", frame_error, wr_addr);
                end
            end
        end
        expect_announce(4);
        tests_run++;
        if (err_cnt != e0 + 1) begin
            tests_failed++;
            $display("FAIL restart_count: got %0d error pulses, required 1", err_cnt - e0);
        end
        release_map();
    endtask

    task automatic test_timeout();
        int t0, v0;
        bit early;
        t0 = to_cnt;
        send_good_frame(8'($urandom_range(0, 255)), 1'b1, 5);
        v0 = vtr_cnt;
        early = 1'b0;
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            if (timeout !== 1'b0 || s_ready !== 1'b0) early = 1'b1;
        end
        tests_run++;
        if (early) begin
            tests_failed++;
            $display("FAIL timeout_early: got timeout or s_ready before cycle %0d, required none", TO);
        end
        @(negedge clk);
        tests_run++;
        if (timeout !== 1'b1 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_fire: got timeout=%0b s_ready=%0b, required 1 1", timeout, s_ready);
        end
        detection_valid = 1'b1;
        repeat (3) idle_cycle();
        detection_valid = 1'b0;
        repeat (2) idle_cycle();
        tests_run++;
        if (s_ready !== 1'b1 || vtr_cnt != v0 || frames_written !== 16'd5 || to_cnt != t0 + 1) begin
            tests_failed++;
            $display("FAIL timeout_after: got s_ready=%0b announces=%0d frames=%0d timeouts=%0d, required 1 0 5 1",
                     s_ready, vtr_cnt - v0, frames_written, to_cnt - t0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0, t0;
        logic [7:0] d;
        threshold = 8'd128;
        for (int i = 0; i < 15; i++) begin
            d = 8'($urandom_range(0, 255));
            push_write(i, d, 8'd128);
            send_beat(d, i == 0, 1'b0);
        end
        s_valid = 1'b1;
        s_data  = 8'd255;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        v0 = vtr_cnt;
        t0 = to_cnt;
        tests_run++;
        if ({wr_en, valid_to_read, frame_error, timeout} !== 4'b0000 || wr_addr !== '0 ||
            wr_data !== 2'b00 || frames_written !== 16'd0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midframe_reset: got wr_en=%0b addr=%0d data=%0d frames=%0d s_ready=%0b, required 0 0 0 0 1",
                     wr_en, wr_addr, wr_data, frames_written, s_ready);
        end
        repeat (3) idle_cycle();
        s_valid = 1'b0;
        rst_n = 1'b1;
        repeat (80) idle_cycle();
        tests_run++;
        if (vtr_cnt != v0 || to_cnt != t0 || frames_written !== 16'd0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL midframe_after: got announces=%0d timeouts=%0d frames=%0d pending=%0d, required 0 0 0 0",
                     vtr_cnt - v0, to_cnt - t0, frames_written, exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ramp_frame();
        test_no_sof();
        test_early_eof();
        test_sof_restart();
        test_timeout();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
